// File: rtl/qpll_relock_ctrl.sv
// qpll_relock_ctrl: QPLL reset/relock sequencer with lock qualification, retry limit and loss-of-lock filter
// Ports:
//   clk_i, rst_i (async, active high)
//   enable_i      sequencer enable, low forces IDLE
//   qpll_lock_i   QPLL lock (synchronous to clk_i)
//   qpll_error_i  QPLL error (synchronous to clk_i)
//   clr_fail_i    single-cycle request to leave FAIL
//   rst_qpll_o    QPLL reset, active high
//   dwn_rst_o     downstream reset hold, active high
//   locked_ok_o   high only in RUN
//   fail_o        high only in FAIL
//   retry_cnt_o   lock timeouts in the current attempt series
//   loss_cnt_o    saturating count of RUN-to-PULSE relocks
//   state_o       state code
module qpll_relock_ctrl #(
   parameter int RST_WIDTH = 40,
   parameter int LOCK_TMO  = 4000,
   parameter int SETTLE    = 1000,
   parameter int LOSS_FILT = 16,
   parameter int MAX_RETRY = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       qpll_lock_i,
   input  logic       qpll_error_i,
   input  logic       clr_fail_i,
   output logic       rst_qpll_o,
   output logic       dwn_rst_o,
   output logic       locked_ok_o,
   output logic       fail_o,
   output logic [2:0] retry_cnt_o,
   output logic [7:0] loss_cnt_o,
   output logic [2:0] state_o
);
   localparam int MAXC = (LOCK_TMO > SETTLE) ? ((LOCK_TMO > RST_WIDTH) ? LOCK_TMO : RST_WIDTH)
                                             : ((SETTLE > RST_WIDTH) ? SETTLE : RST_WIDTH);
   localparam int CW = $clog2(MAXC) + 1;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PULSE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_FAIL   = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    retry_q, retry_d;
   logic [7:0]    loss_q, loss_d;
   logic          rst_qpll_q, rst_qpll_d;
   logic          dwn_rst_q, dwn_rst_d;
   logic          locked_ok_q, locked_ok_d;
   logic          fail_q, fail_d;
   logic          good;
   logic [2:0]    retry_inc;

   assign good      = qpll_lock_i & ~qpll_error_i;
   assign retry_inc = retry_q + 3'd1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         rst_qpll_q  <= 1'b0;
         dwn_rst_q   <= 1'b1;
         locked_ok_q <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         rst_qpll_q  <= rst_qpll_d;
         dwn_rst_q   <= dwn_rst_d;
         locked_ok_q <= locked_ok_d;
         fail_q      <= fail_d;
      end
   end

   always_comb begin
      state_d = S_IDLE;
      retry_d = retry_q;
      loss_d  = loss_q;
      if (enable_i) begin
         case (state_q)
            S_IDLE:   state_d = S_PULSE;
            S_PULSE:  state_d = (cnt_q == CW'(RST_WIDTH - 1)) ? S_WAIT : S_PULSE;
            S_WAIT: begin
               // a good sample on the last timeout cycle still wins
               if (good) state_d = S_SETTLE;
               else if (cnt_q == CW'(LOCK_TMO - 1)) begin
                  retry_d = retry_inc;
                  state_d = (retry_inc >= 3'(MAX_RETRY)) ? S_FAIL : S_PULSE;
               end else state_d = S_WAIT;
            end
            S_SETTLE: state_d = !good ? S_WAIT : (cnt_q == CW'(SETTLE - 1)) ? S_RUN : S_SETTLE;
            S_RUN:    state_d = (!good && cnt_q == CW'(LOSS_FILT - 1)) ? S_PULSE : S_RUN;
            S_FAIL: begin
               state_d = clr_fail_i ? S_PULSE : S_FAIL;
               retry_d = clr_fail_i ? 3'd0 : retry_q;
            end
            default:  state_d = S_IDLE;
         endcase
      end
      if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;
      if (state_q == S_RUN && state_d == S_PULSE && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
      // one shared counter: cycle count in PULSE/WAIT/SETTLE, consecutive-bad count in RUN
      cnt_d = (state_d != state_q || state_q == S_IDLE || state_q == S_FAIL || (state_q == S_RUN && good))
              ? '0 : cnt_q + 1'b1;
   end

   always_comb begin
      rst_qpll_d  = state_d == S_PULSE;
      dwn_rst_d   = state_d != S_RUN;
      locked_ok_d = state_d == S_RUN;
      fail_d      = state_d == S_FAIL;
   end

   assign rst_qpll_o  = rst_qpll_q;
   assign dwn_rst_o   = dwn_rst_q;
   assign locked_ok_o = locked_ok_q;
   assign fail_o      = fail_q;
   assign retry_cnt_o = retry_q;
   assign loss_cnt_o  = loss_q;
   assign state_o     = state_q;
endmodule
